// File: rtl/uart_sample_framer.sv
// Sample FIFO feeding the UART transmitter: each 16-bit sample leaves as
// HEADER, MSB, LSB, XOR checksum, paced by the transmitter's TX_Ready handshake.
module uart_sample_framer #(
  parameter int         DEPTH_LOG2 = 3,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           sample_in,
  input  logic                  sample_valid,
  input  logic                  TX_Ready,
  output logic                  TX_en,
  output logic [7:0]            TX_Data_in,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic                  busy
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_LO, WAIT_HI} state_e;

  state_e                  state_q, state_d;
  logic [15:0]             mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]     level_q;
  logic                    ovf_q;
  logic [15:0]             frame_q, frame_d;
  logic [1:0]              idx_q, idx_d;
  logic                    txen_q, txen_d;
  logic [7:0]              data_q, data_d;
  logic [7:0]              cur_byte;
  logic                    pop, push_ok, drop;

  // A pop in the same cycle frees the slot, so a push at full level is still taken.
  assign pop     = (state_q == LOAD) && (level_q != '0);
  assign push_ok = sample_valid && ((level_q != FULL) || pop);
  assign drop    = sample_valid && !push_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push_ok) level_q <= level_q - 1'b1;
      if (drop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= sample_in;
  end

  always_comb begin
    cur_byte = HEADER;
    case (idx_q)
      2'd1:    cur_byte = frame_q[15:8];
      2'd2:    cur_byte = frame_q[7:0];
      2'd3:    cur_byte = HEADER ^ frame_q[15:8] ^ frame_q[7:0];
      default: cur_byte = HEADER;
    endcase
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    txen_d  = 1'b0;
    data_d  = data_q;
    case (state_q)
      IDLE:    if (level_q != '0) state_d = LOAD;
      LOAD: begin
        frame_d = mem_q[rptr_q];
        idx_d   = '0;
        state_d = SEND;
      end
      SEND: if (TX_Ready) begin
        txen_d  = 1'b1;
        data_d  = cur_byte;
        state_d = WAIT_LO;
      end
      WAIT_LO: if (!TX_Ready) state_d = WAIT_HI;
      WAIT_HI: if (TX_Ready) begin
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 1'b1;
          state_d = SEND;
        end else begin
          state_d = (level_q != '0) ? LOAD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      txen_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      txen_q  <= txen_d;
      data_q  <= data_d;
    end
  end

  assign TX_en      = txen_q;
  assign TX_Data_in = data_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != IDLE);
endmodule
